// File: rtl/vram_dp.sv
// Dual-port video RAM: CPU port A (byte-enabled write, registered read), display port B
// (read-only, every cycle) and a whole-buffer fill engine that owns port A while it runs.
module vram_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1200,
    parameter int ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_W/8-1:0]   cpu_be,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_din,
    output logic [DATA_W-1:0]     cpu_dout,
    output logic                  cpu_rvalid,
    output logic                  cpu_stall,
    input  logic [ADDR_W-1:0]     vga_addr,
    output logic [DATA_W-1:0]     vga_dout,
    input  logic                  fill_start,
    input  logic [DATA_W-1:0]     fill_value,
    output logic                  busy,
    output logic                  fill_done,
    output logic                  dbg_state
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fill_cnt;
    logic [DATA_W-1:0]   fill_val;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                fill_accept;
    logic                cpu_go;
    logic                cpu_in_range;
    logic                vga_in_range;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NB-1:0]       wr_be;

    // Handshake: a CPU request is taken on the rising edge when cpu_req=1 and cpu_stall=0;
    // a stalled request has no effect and must be held by the master until accepted.
    assign fill_accept  = fill_start && (state == ST_IDLE);
    assign cpu_stall    = busy || fill_accept;
    assign cpu_go       = cpu_req && !cpu_stall;
    assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH_X);
    assign vga_in_range = ({1'b0, vga_addr} < DEPTH_X);
    assign dbg_state    = (state == ST_FILL);

    // Port A write source: the fill engine has priority; the CPU can never collide with it
    // because it is stalled for the whole fill.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        if (state == ST_FILL) begin
            wr_en   = 1'b1;
            wr_addr = fill_cnt;
            wr_data = fill_val;
            wr_be   = '1;
        end else if (cpu_go && cpu_we && cpu_in_range) begin
            wr_en   = 1'b1;
            wr_addr = cpu_addr;
            wr_data = cpu_din;
            wr_be   = cpu_be;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read ports sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_dout   <= '0;
            cpu_rvalid <= 1'b0;
            vga_dout   <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (cpu_go && !cpu_we) begin
                cpu_rvalid <= 1'b1;
                cpu_dout   <= cpu_in_range ? mem[cpu_addr] : '0;
            end
            vga_dout <= vga_in_range ? mem[vga_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            fill_val  <= '0;
            busy      <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state    <= ST_FILL;
                        busy     <= 1'b1;
                        fill_cnt <= '0;
                        fill_val <= fill_value;
                    end
                end
                ST_FILL: begin
                    if (fill_cnt == LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        fill_done <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_dp.sv
// Bench for vram_dp: cycle-numbered memory model checked every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_vram_dp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1200;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [3:0]        cpu_be = 4'h0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_din = '0;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_rvalid;
    logic              cpu_stall;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic [DATA_W-1:0] vga_dout;
    logic              fill_start = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;
    logic              busy;
    logic              fill_done;
    logic              dbg_state;

    vram_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .vga_addr(vga_addr), .vga_dout(vga_dout),
        .fill_start(fill_start), .fill_value(fill_value),
        .busy(busy), .fill_done(fill_done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // model: memory image plus fill timing expressed as edge numbers
    logic [DATA_W-1:0] mem_val [DEPTH];
    bit                mem_known [DEPTH];
    int                edge_cnt = 0;
    int                fill_edge = 0;
    bit                fill_on = 1'b0;
    logic [DATA_W-1:0] fill_val_m = '0;
    bit                exp_busy = 1'b0;
    bit                exp_done = 1'b0;
    bit                exp_rvalid = 1'b0;
    logic [DATA_W-1:0] exp_dout = '0;
    bit                exp_dout_known = 1'b1;
    logic [DATA_W-1:0] exp_vga = '0;
    bit                exp_vga_known = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_on        = 1'b0;
            exp_busy       = 1'b0;
            exp_done       = 1'b0;
            exp_rvalid     = 1'b0;
            exp_dout       = '0;
            exp_dout_known = 1'b1;
            exp_vga        = '0;
            exp_vga_known  = 1'b1;
        end else begin
            bit stall;
            bit was_busy;
            int a;
            edge_cnt++;
            was_busy = exp_busy;
            stall = was_busy || fill_start;
            a = int'(vga_addr);
            if (a < DEPTH) begin
                exp_vga = mem_val[a];
                exp_vga_known = mem_known[a];
            end else begin
                exp_vga = '0;
                exp_vga_known = 1'b1;
            end
            exp_rvalid = 1'b0;
            a = int'(cpu_addr);
            if (cpu_req && !cpu_we && !stall) begin
                exp_rvalid = 1'b1;
                if (a < DEPTH) begin
                    exp_dout = mem_val[a];
                    exp_dout_known = mem_known[a];
                end else begin
                    exp_dout = '0;
                    exp_dout_known = 1'b1;
                end
            end
            if (fill_on && edge_cnt > fill_edge && edge_cnt <= fill_edge + DEPTH) begin
                mem_val[edge_cnt - fill_edge - 1] = fill_val_m;
                mem_known[edge_cnt - fill_edge - 1] = 1'b1;
            end
            if (cpu_req && cpu_we && !stall && a < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_be[b]) mem_val[a][8*b +: 8] = cpu_din[8*b +: 8];
                if (cpu_be == 4'hF) mem_known[a] = 1'b1;
            end
            exp_done = fill_on && (edge_cnt == fill_edge + DEPTH);
            if (fill_start && !was_busy) begin
                fill_on = 1'b1;
                fill_edge = edge_cnt;
                fill_val_m = fill_value;
            end
            exp_busy = fill_on && edge_cnt >= fill_edge && edge_cnt < fill_edge + DEPTH;
        end
    end

    // scoreboard compare, mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            check("m_busy", {31'b0, busy}, {31'b0, exp_busy});
            check("m_state", {31'b0, dbg_state}, {31'b0, exp_busy});
            check("m_fill_done", {31'b0, fill_done}, {31'b0, exp_done});
            check("m_rvalid", {31'b0, cpu_rvalid}, {31'b0, exp_rvalid});
            check("m_stall", {31'b0, cpu_stall}, {31'b0, exp_busy || fill_start});
            if (exp_dout_known) check("m_cpu_dout", cpu_dout, exp_dout);
            if (exp_vga_known) check("m_vga_dout", vga_dout, exp_vga);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d; cpu_be = be;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        tick();
        cpu_req = 1'b0;
        check({name, "_rvalid"}, {31'b0, cpu_rvalid}, 32'd1);
        check(name, cpu_dout, exp);
        tick();
        check({name, "_rvalid_drop"}, {31'b0, cpu_rvalid}, 32'd0);
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] e;

        @(posedge clk);
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_cpu_dout", cpu_dout, 32'h0);
        check("rst_vga_dout", vga_dout, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check("rst_fill_done", {31'b0, fill_done}, 32'd0);
        rst_n = 1'b1;
        tick();

        cpu_write(11'd5, 32'hDEADBEEF, 4'hF);
        cpu_read(11'd5, 32'hDEADBEEF, "rd5");

        cpu_write(11'd7, 32'h11223344, 4'hF);
        cpu_write(11'd7, 32'hAABBCCDD, 4'b0101);
        cpu_read(11'd7, 32'h11BB33DD, "rd7_be");

        cpu_write(11'd1199, 32'h12345678, 4'hF);
        cpu_write(11'd1200, 32'h00000055, 4'hF);
        cpu_read(11'd1200, 32'h0, "rd1200_oor");
        cpu_read(11'd1199, 32'h12345678, "rd1199");
        vga_addr = 11'd1300;
        tick();
        check("vga1300_oor", vga_dout, 32'h0);

        // fill competes with a CPU read in the same cycle
        fill_start = 1'b1; fill_value = 32'h20;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
        #1;
        check("fill_vs_cpu_stall", {31'b0, cpu_stall}, 32'd1);
        tick();
        fill_start = 1'b0; cpu_req = 1'b0;
        check("fill_busy_rise", {31'b0, busy}, 32'd1);
        check("fill_cpu_no_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        n = 0;
        while (busy && n < 2000) begin
            if (n == 5) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd3; cpu_din = 32'hBAD0BAD0; cpu_be = 4'hF;
                #1;
                check("stall_in_fill", {31'b0, cpu_stall}, 32'd1);
            end
            tick();
            cpu_req = 1'b0; cpu_we = 1'b0;
            n++;
        end
        check("fill_busy_cycles", n, 32'd1200);
        check("fill_done_pulse", {31'b0, fill_done}, 32'd1);
        tick();
        check("fill_done_drop", {31'b0, fill_done}, 32'd0);

        for (int a = 0; a < DEPTH; a++) begin
            vga_addr = 11'(a);
            tick();
            check("sweep_fill20", vga_dout, 32'h20);
        end

        // same-address write/read collision returns the old word
        vga_addr = 11'd10;
        cpu_write(11'd10, 32'hCAFEF00D, 4'hF);
        check("collide_old", vga_dout, 32'h20);
        tick();
        check("collide_new", vga_dout, 32'hCAFEF00D);
        cpu_read(11'd10, 32'hCAFEF00D, "rd10");

        // reset after 600 fill writes
        fill_start = 1'b1; fill_value = 32'h77;
        tick();
        fill_start = 1'b0;
        repeat (600) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_vga", vga_dout, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            vga_addr = 11'(a);
            tick();
            e = (a < 600) ? 32'h77 : 32'h20;
            check("sweep_midrst", vga_dout, e);
        end

        fill_start = 1'b1; fill_value = 32'h5A;
        tick();
        fill_start = 1'b0;
        check("refill_busy", {31'b0, busy}, 32'd1);
        wait_busy_low(n);
        check("refill_cycles", n, 32'd1200);
        check("refill_done", {31'b0, fill_done}, 32'd1);

        // back-to-back fill in the fill_done cycle
        fill_start = 1'b1; fill_value = 32'h33;
        #1;
        check("b2b_stall", {31'b0, cpu_stall}, 32'd1);
        tick();
        fill_start = 1'b0;
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_busy_low(n);
        check("b2b_cycles", n, 32'd1200);
        check("b2b_done", {31'b0, fill_done}, 32'd1);
        tick();
        vga_addr = 11'd0;
        tick();
        check("b2b_vga0", vga_dout, 32'h33);
        cpu_read(11'd1199, 32'h33, "b2b_rd1199");

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
